// File: rtl/brick_ball_engine.sv
// rtl/brick_ball_engine.sv - Breakout per-frame ball/paddle/brick physics engine
// Optional BRICK_MULTI_HIT_EN: bricks take three hits (damage 1, 2, 3) instead of one.
module brick_ball_engine #(
  parameter int BALL_SIZE = 7,
  parameter int SPEED     = 2,
  parameter int PADDLE_W  = 100
) (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic [9:0] paddle_pos,
  input  logic       launch,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       active_write_enable,
  output logic [5:0] active_position,
  output logic [1:0] active_data,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       frame_busy
);
  typedef logic signed [11:0] s12_t;
  typedef enum logic [2:0] {IDLE, MOVE, BOUNCE, SCAN, COMMIT} state_t;

  localparam s12_t BS = s12_t'(BALL_SIZE);
  localparam s12_t PW = s12_t'(PADDLE_W);
  localparam logic signed [10:0] SPD = 11'(SPEED);

  state_t            state_q;
  logic [9:0]        ball_x_q, ball_y_q;
  logic signed [10:0] nx_q, ny_q;
  logic              dx_q, dy_q, serving_q, hit_q;
  logic [3:0]        scan_idx_q, hit_idx_q;
  logic [1:0]        dmg_q [0:9];
  logic              awe_q, game_over_q, frame_busy_q;
  logic [5:0]        pos_q;
  logic [1:0]        data_q, lives_q, new_dmg;
  logic [7:0]        score_q;

  s12_t nx_e, ny_e, pad_e, bnx_d, bny_d, brk_x0, brk_y0;
  logic bdx_d, bdy_d, floor_d, brick_hit, tick;
  logic [2:0] col;

  assign nx_e  = s12_t'(nx_q);
  assign ny_e  = s12_t'(ny_q);
  assign pad_e = $signed({2'b00, paddle_pos});
  assign tick  = (hor_count == 10'd640) && (ver_count == 10'd480) && !game_over_q;

  // Wall/paddle checks are order dependent: each sees the previous one's result.
  always_comb begin
    bnx_d = nx_e;
    bny_d = ny_e;
    bdx_d = dx_q;
    bdy_d = dy_q;
    if (bnx_d < 12'sd0) begin
      bnx_d = 12'sd0;
      bdx_d = 1'b1;
    end
    if (bnx_d + BS > 12'sd639) begin
      bnx_d = 12'sd639 - BS;
      bdx_d = 1'b0;
    end
    if (bny_d < 12'sd0) begin
      bny_d = 12'sd0;
      bdy_d = 1'b1;
    end
    if (bdy_d && (bnx_d <= pad_e + PW - 12'sd1) && (bnx_d + BS >= pad_e + 12'sd1) &&
        (bny_d <= 12'sd449) && (bny_d + BS >= 12'sd441)) begin
      bny_d = 12'sd433;
      bdy_d = 1'b0;
    end
    floor_d = (bny_d + BS > 12'sd479);
  end

  always_comb begin
    col = (scan_idx_q >= 4'd5) ? 3'(scan_idx_q - 4'd5) : scan_idx_q[2:0];
    case (col)
      3'd0:    brk_x0 = 12'sd40;
      3'd1:    brk_x0 = 12'sd160;
      3'd2:    brk_x0 = 12'sd280;
      3'd3:    brk_x0 = 12'sd400;
      default: brk_x0 = 12'sd520;
    endcase
    brk_y0    = (scan_idx_q >= 4'd5) ? 12'sd90 : 12'sd40;
    brick_hit = (dmg_q[scan_idx_q] != 2'd3) &&
                (nx_e <= brk_x0 + 12'sd80) && (nx_e + BS >= brk_x0) &&
                (ny_e <= brk_y0 + 12'sd30) && (ny_e + BS >= brk_y0);
  end

  always_comb begin
`ifdef BRICK_MULTI_HIT_EN
    new_dmg = dmg_q[hit_idx_q] + 2'd1;
`else
    new_dmg = 2'd3;
`endif
  end

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      state_q      <= IDLE;
      ball_x_q     <= 10'd316;
      ball_y_q     <= 10'd432;
      nx_q         <= 11'sd0;
      ny_q         <= 11'sd0;
      dx_q         <= 1'b1;
      dy_q         <= 1'b0;
      serving_q    <= 1'b1;
      hit_q        <= 1'b0;
      scan_idx_q   <= 4'd0;
      hit_idx_q    <= 4'd0;
      awe_q        <= 1'b0;
      pos_q        <= 6'd0;
      data_q       <= 2'd0;
      score_q      <= 8'd0;
      lives_q      <= 2'd3;
      game_over_q  <= 1'b0;
      frame_busy_q <= 1'b0;
      for (int i = 0; i < 10; i++) dmg_q[i] <= 2'd0;
    end else begin
      awe_q <= 1'b0;
      case (state_q)
        IDLE: if (tick) begin
          frame_busy_q <= 1'b1;
          if (serving_q) begin
            nx_q    <= $signed({1'b0, paddle_pos}) + 11'sd46;
            ny_q    <= 11'sd432;
            hit_q   <= 1'b0;
            state_q <= COMMIT;
            if (launch) begin
              serving_q <= 1'b0;
              dx_q      <= 1'b1;
              dy_q      <= 1'b0;
            end
          end else begin
            state_q <= MOVE;
          end
        end
        MOVE: begin
          nx_q       <= $signed({1'b0, ball_x_q}) + (dx_q ? SPD : -SPD);
          ny_q       <= $signed({1'b0, ball_y_q}) + (dy_q ? SPD : -SPD);
          hit_q      <= 1'b0;
          scan_idx_q <= 4'd0;
          state_q    <= BOUNCE;
        end
        BOUNCE: begin
          nx_q <= bnx_d[10:0];
          ny_q <= bny_d[10:0];
          dx_q <= bdx_d;
          dy_q <= bdy_d;
          if (floor_d) begin
            lives_q   <= lives_q - 2'd1;
            serving_q <= 1'b1;
            if (lives_q == 2'd1) game_over_q <= 1'b1;
            state_q   <= COMMIT;
          end else begin
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (!hit_q && brick_hit) begin
            hit_q     <= 1'b1;
            hit_idx_q <= scan_idx_q;
          end
          if (scan_idx_q == 4'd9) state_q <= COMMIT;
          else scan_idx_q <= scan_idx_q + 4'd1;
        end
        COMMIT: begin
          ball_x_q <= nx_q[9:0];
          // A brick hit reflects vertically, so the ball keeps its previous row.
          ball_y_q <= hit_q ? ball_y_q : ny_q[9:0];
          if (hit_q) begin
            dy_q             <= ~dy_q;
            dmg_q[hit_idx_q] <= new_dmg;
            awe_q            <= 1'b1;
            pos_q            <= {2'b00, hit_idx_q};
            data_q           <= new_dmg;
            if (new_dmg == 2'd3) begin
              score_q <= score_q + 8'd1;
              if (score_q == 8'd9) game_over_q <= 1'b1;
            end
          end
          frame_busy_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ball_x              = ball_x_q;
  assign ball_y              = ball_y_q;
  assign active_write_enable = awe_q;
  assign active_position     = pos_q;
  assign active_data         = data_q;
  assign score               = score_q;
  assign lives               = lives_q;
  assign game_over           = game_over_q;
  assign frame_busy          = frame_busy_q;
endmodule
